playfield_mem_ctrl: RTL and testbench

PLAYFIELD_MEM_CTRL -- requirements
Module: playfield_mem_ctrl

---
 rtl/playfield_mem_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_playfield_mem_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/playfield_mem_ctrl.sv
// Playfield memory controller: clears the playfield at start-up, redraws the
// falling piece on each vertical sync and streams single rows back out of
// memory through the read FIFO.
module playfield_mem_ctrl #(
  parameter int COLS = 10,
  parameter int ROWS = 20,
  parameter int NBLK = 4,
  parameter int DW   = 16,
  parameter int AW   = 25,
  parameter int GAP  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vs,
  input  logic                      row_ld,
  input  logic [7:0]                row,
  input  logic [NBLK-1:0][6:0]      pre_x,
  input  logic [NBLK-1:0][6:0]      pre_y,
  input  logic [NBLK-1:0][6:0]      post_x,
  input  logic [NBLK-1:0][6:0]      post_y,
  input  logic [DW-1:0]             blk_color,
  input  logic [DW-1:0]             bg_color,
  input  logic [15:0]               wr_buffer,
  input  logic [15:0]               rd_buffer,
  input  logic [DW-1:0]             readdata,
  output logic                      write_ld,
  output logic                      write_req,
  output logic [AW-1:0]             writeaddr,
  output logic [DW-1:0]             writedata,
  output logic                      read_ld,
  output logic                      read_req,
  output logic [AW-1:0]             readaddr,
  output logic [COLS-1:0][DW-1:0]   row_data,
  output logic                      row_ready,
  output logic                      init_done,
  output logic                      busy
);

  localparam int TOTAL = COLS * ROWS;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int NC    = 2 * NBLK;
  localparam int IW    = $clog2(NC + 1);
  localparam int KW    = $clog2(COLS + 1);
  localparam int GW    = $clog2(GAP + 1) + 1;

  typedef enum logic [3:0] {
    INIT, IDLE, W_LD, W_REQ, W_GAP, W_DRAIN, R_LD, R_WAIT, R_BURST, R_DONE
  } state_t;

  state_t state, next_state;

  logic              vs_d, upd_pend, row_pend;
  logic [7:0]        row_q;
  logic [CW-1:0]     cnt;
  logic [GW-1:0]     gap_cnt;
  logic [KW-1:0]     k;
  logic [IW-1:0]     idx;
  logic [NBLK-1:0][6:0] pre_x_q, pre_y_q, post_x_q, post_y_q;
  logic [DW-1:0]     bg_q, blk_q;

  logic              vs_rise, row_ok;
  logic              take_upd, take_row, load_init, load_upd;
  logic [NC-1:0]     cell_ok;
  logic [NC-1:0][AW-1:0] cell_addr;
  logic [NBLK-1:0]   overlap;
  logic              found;
  logic [IW-1:0]     sel;
  logic [AW-1:0]     f_addr;
  logic [DW-1:0]     f_data;

  assign vs_rise = vs & ~vs_d;
  assign row_ok  = 32'(row_q) < ROWS;

  // Cell list of an update: entries 0..NBLK-1 erase the old piece, the rest draw the new one
  always_comb begin
    cell_ok   = '0;
    cell_addr = '0;
    overlap   = '0;
    for (int i = 0; i < NBLK; i++) begin
      for (int j = 0; j < NBLK; j++) begin
        if (pre_x_q[i] == post_x_q[j] && pre_y_q[i] == post_y_q[j]) overlap[i] = 1'b1;
      end
      cell_ok[i] = (32'(pre_x_q[i]) < COLS) && (32'(pre_y_q[i]) < ROWS) && !overlap[i];
      cell_ok[NBLK+i] = (32'(post_x_q[i]) < COLS) && (32'(post_y_q[i]) < ROWS);
      cell_addr[i] = AW'(pre_y_q[i]) * AW'(COLS) + AW'(pre_x_q[i]);
      cell_addr[NBLK+i] = AW'(post_y_q[i]) * AW'(COLS) + AW'(post_x_q[i]);
    end
  end

  // Pick the lowest-numbered writable cell at or after idx
  always_comb begin
    found  = 1'b0;
    sel    = '0;
    f_addr = '0;
    f_data = '0;
    for (int j = NC - 1; j >= 0; j--) begin
      if (j >= int'(idx) && cell_ok[j]) begin
        found  = 1'b1;
        sel    = IW'(j);
        f_addr = cell_addr[j];
        f_data = (j < NBLK) ? bg_q : blk_q;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= next_state;
  end

  // Next-state decode plus the strobes that depend only on the current state
  always_comb begin
    next_state = state;
    take_upd   = 1'b0;
    take_row   = 1'b0;
    load_init  = 1'b0;
    load_upd   = 1'b0;
    write_ld   = (state == W_LD);
    write_req  = (state == W_REQ);
    read_ld    = (state == R_LD);
    read_req   = (state == R_BURST);
    row_ready  = (state == R_DONE);
    busy       = (state != IDLE);
    case (state)
      INIT: begin
        if (32'(cnt) < TOTAL) begin
          load_init  = 1'b1;
          next_state = W_LD;
        end else if (wr_buffer == 16'd0) begin
          next_state = IDLE;
        end
      end
      IDLE: begin
        if (upd_pend) begin
          take_upd   = 1'b1;
          next_state = W_DRAIN;
        end else if (row_pend) begin
          take_row = 1'b1;
          if (row_ok) next_state = R_LD;
        end
      end
      W_LD:    next_state = W_REQ;
      W_REQ:   next_state = (GAP == 0) ? W_DRAIN : W_GAP;
      W_GAP:   if (gap_cnt == GW'(GAP - 1)) next_state = W_DRAIN;
      W_DRAIN: begin
        if (wr_buffer == 16'd0) begin
          if (!init_done) begin
            next_state = INIT;
          end else if (found) begin
            load_upd   = 1'b1;
            next_state = W_LD;
          end else begin
            next_state = IDLE;
          end
        end
      end
      R_LD:    next_state = R_WAIT;
      R_WAIT:  if (rd_buffer == 16'(COLS)) next_state = R_BURST;
      R_BURST: if (k == KW'(COLS - 1)) next_state = R_DONE;
      R_DONE:  next_state = IDLE;
      default: next_state = INIT;
    endcase
  end

  // Event flags, sampled update inputs, address/data registers and row capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_d      <= 1'b0;
      upd_pend  <= 1'b0;
      row_pend  <= 1'b0;
      row_q     <= '0;
      cnt       <= '0;
      gap_cnt   <= '0;
      k         <= '0;
      idx       <= '0;
      pre_x_q   <= '0;
      pre_y_q   <= '0;
      post_x_q  <= '0;
      post_y_q  <= '0;
      bg_q      <= '0;
      blk_q     <= '0;
      writeaddr <= '0;
      writedata <= '0;
      readaddr  <= '0;
      row_data  <= '0;
      init_done <= 1'b0;
    end else begin
      vs_d <= vs;
      if (take_upd) upd_pend <= 1'b0;
      if (vs_rise)  upd_pend <= 1'b1;
      if (take_row) row_pend <= 1'b0;
      if (row_ld && (!row_pend || take_row)) begin
        row_pend <= 1'b1;
        row_q    <= row;
      end
      if (load_init) begin
        writeaddr <= AW'(cnt);
        writedata <= bg_color;
        cnt       <= cnt + CW'(1);
      end
      if (state == INIT && !load_init) init_done <= 1'b1;
      if (take_upd) begin
        pre_x_q  <= pre_x;
        pre_y_q  <= pre_y;
        post_x_q <= post_x;
        post_y_q <= post_y;
        bg_q     <= bg_color;
        blk_q    <= blk_color;
        idx      <= '0;
      end
      if (load_upd) begin
        writeaddr <= f_addr;
        writedata <= f_data;
        idx       <= sel + IW'(1);
      end
      if (state == W_REQ)      gap_cnt <= '0;
      else if (state == W_GAP) gap_cnt <= gap_cnt + GW'(1);
      if (take_row && row_ok) readaddr <= AW'(row_q) * AW'(COLS);
      if (state == R_LD) k <= '0;
      if (state == R_BURST) begin
        row_data[k] <= readdata;
        k           <= k + KW'(1);
      end
    end
  end

endmodule

// File: tb/tb_playfield_mem_ctrl.sv
// Scoreboard bench for playfield_mem_ctrl: expected writes, read addresses and
// row contents are queued as stimulus is applied and checked by a monitor.
module tb_playfield_mem_ctrl;

  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int NBLK = 4;
  localparam int DW   = 16;
  localparam int AW   = 25;
  localparam int GAP  = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset, vs, row_ld;
  logic [7:0] row;
  logic [NBLK-1:0][6:0] pre_x, pre_y, post_x, post_y;
  logic [DW-1:0] blk_color, bg_color, readdata;
  logic [15:0] wr_buffer, rd_buffer;
  logic write_ld, write_req, read_ld, read_req, row_ready, init_done, busy;
  logic [AW-1:0] writeaddr, readaddr;
  logic [DW-1:0] writedata;
  logic [COLS-1:0][DW-1:0] row_data;

  int n_checks = 0;
  int n_fail   = 0;
  wr_t wq[$];
  int  rq[$];
  int  rowq[$];
  wr_t e;
  int  exp_rd, exp_base;
  int  wr_count = 0, rdld_count = 0, rr_count = 0;
  bit  prev_ld = 0, have_req = 0;
  int  since_req = 0;

  playfield_mem_ctrl #(.COLS(COLS), .ROWS(ROWS), .NBLK(NBLK), .DW(DW), .AW(AW), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .vs(vs), .row_ld(row_ld), .row(row),
    .pre_x(pre_x), .pre_y(pre_y), .post_x(post_x), .post_y(post_y),
    .blk_color(blk_color), .bg_color(bg_color),
    .wr_buffer(wr_buffer), .rd_buffer(rd_buffer), .readdata(readdata),
    .write_ld(write_ld), .write_req(write_req), .writeaddr(writeaddr), .writedata(writedata),
    .read_ld(read_ld), .read_req(read_req), .readaddr(readaddr),
    .row_data(row_data), .row_ready(row_ready), .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Monitor: compares every write, read address load and finished row against the queues
  always @(negedge clk) begin
    if (reset) begin
      prev_ld  = 0;
      have_req = 0;
    end else begin
      since_req++;
      if (write_ld && have_req) checkOutput("wr_gap", 64'(since_req > GAP), 1);
      if (write_req) begin
        checkOutput("wr_after_ld", 64'(prev_ld), 1);
        if (wq.size() == 0) begin
          checkOutput("unexpected_wr", 64'(writeaddr), 64'hFFFF_FFFF);
        end else begin
          e = wq.pop_front();
          checkOutput("wr_addr", 64'(writeaddr), 64'(e.addr));
          checkOutput("wr_data", 64'(writedata), 64'(e.data));
        end
        wr_count++;
        have_req  = 1;
        since_req = 0;
      end
      prev_ld = write_ld;
      if (read_ld) begin
        rdld_count++;
        checkOutput("rd_after_upd", 64'(wq.size()), 0);
        if (rq.size() == 0) checkOutput("unexpected_rd", 64'(readaddr), 64'hFFFF_FFFF);
        else begin
          exp_rd = rq.pop_front();
          checkOutput("rd_addr", 64'(readaddr), 64'(exp_rd));
        end
      end
      if (row_ready) begin
        rr_count++;
        if (rowq.size() == 0) checkOutput("unexpected_row_ready", 1, 0);
        else begin
          exp_base = rowq.pop_front();
          for (int c = 0; c < COLS; c++)
            checkOutput($sformatf("row_data[%0d]", c), 64'(row_data[c]), 64'(exp_base + c + 1));
        end
      end
    end
  end

  // Reference model of an update: erase old cells not covered by the new piece, then draw
  task automatic pushUpdate();
    bit cov;
    for (int i = 0; i < NBLK; i++) begin
      cov = 0;
      for (int j = 0; j < NBLK; j++)
        if (pre_x[i] == post_x[j] && pre_y[i] == post_y[j]) cov = 1;
      if (!cov && pre_x[i] < COLS && pre_y[i] < ROWS)
        wq.push_back('{addr: AW'(int'(pre_y[i]) * COLS + int'(pre_x[i])), data: bg_color});
    end
    for (int i = 0; i < NBLK; i++)
      if (post_x[i] < COLS && post_y[i] < ROWS)
        wq.push_back('{addr: AW'(int'(post_y[i]) * COLS + int'(post_x[i])), data: blk_color});
  endtask

  task automatic pushInit();
    for (int a = 0; a < COLS * ROWS; a++) wq.push_back('{addr: AW'(a), data: bg_color});
  endtask

  task automatic pulseVs();
    vs = 1'b1;
    repeat (2) @(negedge clk);
    vs = 1'b0;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int r);
    row    = 8'(r);
    row_ld = 1'b1;
    @(negedge clk);
    row_ld = 1'b0;
  endtask

  task automatic waitInit();
    int n;
    for (n = 0; n < 4000 && !init_done; n++) @(negedge clk);
    checkOutput("init_done_seen", 64'(init_done), 1);
  endtask

  // Waits until the controller has been idle for several consecutive cycles
  task automatic waitIdle(input int budget);
    int quiet = 0;
    for (int n = 0; n < budget && quiet < 5; n++) begin
      @(negedge clk);
      quiet = busy ? 0 : quiet + 1;
    end
    checkOutput("idle_reached", 64'(quiet >= 5), 1);
  endtask

  // Plays the read FIFO side of one row read, feeding base+1..base+COLS
  task automatic serviceRead(input int base, input int budget);
    int n, cnt;
    for (n = 0; n < budget && !read_ld; n++) @(negedge clk);
    checkOutput("read_ld_seen", 64'(read_ld), 1);
    repeat (3) begin
      @(negedge clk);
      checkOutput("req_waits_fifo", 64'(read_req), 0);
    end
    rd_buffer = 16'(COLS);
    @(negedge clk);
    cnt = 0;
    while (read_req && cnt < 2 * COLS) begin
      readdata = DW'(base + cnt + 1);
      cnt++;
      @(negedge clk);
    end
    rd_buffer = 16'd0;
    checkOutput("burst_len", 64'(cnt), COLS);
    checkOutput("row_ready_pulse", 64'(row_ready), 1);
    @(negedge clk);
    checkOutput("row_ready_once", 64'(row_ready), 0);
  endtask

  initial begin
    int base_wr, base_rd, base_rr, n;
    reset = 1'b1; vs = 1'b0; row_ld = 1'b0; row = '0;
    pre_x = '0; pre_y = '0; post_x = '0; post_y = '0;
    blk_color = 16'hABCD; bg_color = 16'h1234;
    wr_buffer = '0; rd_buffer = '0; readdata = '0;

    // Reset state and start-up clear
    repeat (2) @(negedge clk);
    checkOutput("rst_write_ld", 64'(write_ld), 0);
    checkOutput("rst_read_req", 64'(read_req), 0);
    checkOutput("rst_init_done", 64'(init_done), 0);
    checkOutput("rst_busy", 64'(busy), 1);
    checkOutput("rst_writeaddr", 64'(writeaddr), 0);
    pushInit();
    reset = 1'b0;
    waitInit();
    waitIdle(200);
    checkOutput("init_writes", 64'(wr_count), COLS * ROWS);
    checkOutput("init_q_empty", 64'(wq.size()), 0);

    // Piece move with overlap, plus two extra vs edges while busy that collapse into one
    pre_x  = {7'd5, 7'd4, 7'd5, 7'd4}; pre_y  = {7'd1, 7'd1, 7'd0, 7'd0};
    post_x = {7'd5, 7'd4, 7'd5, 7'd4}; post_y = {7'd2, 7'd2, 7'd1, 7'd1};
    base_wr = wr_count;
    pushUpdate();
    pushUpdate();
    pulseVs();
    pulseVs();
    pulseVs();
    waitIdle(500);
    checkOutput("upd_writes", 64'(wr_count - base_wr), 12);
    checkOutput("upd_q_empty", 64'(wq.size()), 0);

    // Plain row read
    base_rr = rr_count;
    rq.push_back(30);
    rowq.push_back(0);
    applyStimulus(3);
    serviceRead(0, 50);
    waitIdle(50);
    checkOutput("row_ready_count", 64'(rr_count - base_rr), 1);

    // vs edge and row_ld together: update must finish before the read starts
    pre_x  = {7'd3, 7'd2, 7'd1, 7'd0}; pre_y  = {7'd0, 7'd0, 7'd0, 7'd0};
    post_x = {7'd3, 7'd2, 7'd1, 7'd0}; post_y = {7'd1, 7'd1, 7'd1, 7'd1};
    base_wr = wr_count;
    pushUpdate();
    rq.push_back(50);
    rowq.push_back(100);
    vs = 1'b1; row = 8'd5; row_ld = 1'b1;
    @(negedge clk);
    row_ld = 1'b0;
    serviceRead(100, 300);
    vs = 1'b0;
    waitIdle(100);
    checkOutput("both_writes", 64'(wr_count - base_wr), 8);
    checkOutput("both_q_empty", 64'(rq.size() + wq.size() + rowq.size()), 0);

    // Off-board cells are skipped and an out-of-range row is dropped
    pre_x  = {7'd3, 7'd2, 7'd1, 7'd0};  pre_y  = {7'd5, 7'd5, 7'd5, 7'd25};
    post_x = {7'd3, 7'd2, 7'd1, 7'd12}; post_y = {7'd6, 7'd6, 7'd6, 7'd6};
    base_wr = wr_count;
    pushUpdate();
    pulseVs();
    waitIdle(300);
    checkOutput("skip_writes", 64'(wr_count - base_wr), 6);
    base_rd = rdld_count;
    base_rr = rr_count;
    applyStimulus(25);
    for (n = 0; n < 30; n++) @(negedge clk);
    checkOutput("bad_row_no_read", 64'(rdld_count - base_rd), 0);
    checkOutput("bad_row_no_ready", 64'(rr_count - base_rr), 0);
    checkOutput("bad_row_idle", 64'(busy), 0);

    // Reset in the middle of a burst
    rq.push_back(20);
    applyStimulus(2);
    for (n = 0; n < 50 && !read_ld; n++) @(negedge clk);
    checkOutput("rst_rd_ld_seen", 64'(read_ld), 1);
    rd_buffer = 16'(COLS);
    for (n = 0; n < 50 && !read_req; n++) @(negedge clk);
    checkOutput("rst_burst_started", 64'(read_req), 1);
    readdata = 16'h0055;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("midrst_read_req", 64'(read_req), 0);
    checkOutput("midrst_busy", 64'(busy), 1);
    checkOutput("midrst_init_done", 64'(init_done), 0);
    checkOutput("midrst_writeaddr", 64'(writeaddr), 0);
    checkOutput("midrst_row_data0", 64'(row_data[0]), 0);
    wq.delete(); rq.delete(); rowq.delete();
    rd_buffer = 16'd0;
    bg_color  = 16'h0F0F;
    pushInit();
    base_wr = wr_count;
    @(negedge clk);
    reset = 1'b0;
    waitInit();
    waitIdle(200);
    checkOutput("reinit_writes", 64'(wr_count - base_wr), COLS * ROWS);
    checkOutput("reinit_q_empty", 64'(wq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
